// File: rtl/rc4_pkg.sv
// Shared types for the RC4 key-search controller.
// Optional watchdog build switch: RC4_KEY_SEARCH_TIMEOUT_EN.
package rc4_pkg;

    localparam int KEY_WIDTH = 24;

    typedef logic [KEY_WIDTH-1:0] key_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT      = 3'd2,
        ST_FOUND     = 3'd3,
        ST_EXHAUSTED = 3'd4
`ifdef RC4_KEY_SEARCH_TIMEOUT_EN
        ,
        ST_TIMEOUT   = 3'd5
`endif
    } key_search_state_t;

endpackage

// File: rtl/rc4_key_search_ctrl_if.sv
// Handshake between the key-search sequencer (master) and the KSA/decrypt datapath (slave).
// Optional watchdog build switch elsewhere: RC4_KEY_SEARCH_TIMEOUT_EN.
interface rc4_key_search_ctrl_if #(
    parameter int KEY_WIDTH = rc4_pkg::KEY_WIDTH
);

    logic                 dp_start;
    logic [KEY_WIDTH-1:0] secret_key;
    logic                 dp_done;
    logic                 dp_key_found;

    modport master (
        output dp_start,
        output secret_key,
        input  dp_done,
        input  dp_key_found
    );

    modport slave (
        input  dp_start,
        input  secret_key,
        output dp_done,
        output dp_key_found
    );

endinterface

// File: rtl/rc4_key_counter.sv
// Candidate-key register: loads the first key, steps by one, flags the last key of the range.
// Optional watchdog build switch elsewhere: RC4_KEY_SEARCH_TIMEOUT_EN.
module rc4_key_counter #(
    parameter int                   KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
    parameter logic [KEY_WIDTH-1:0] KEY_END   = '1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 inc,
    output logic [KEY_WIDTH-1:0] q,
    output logic                 is_last
);

    // The owner never asks for an increment past KEY_END, so no wrap handling is needed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= KEY_START;
        end else if (load) begin
            q <= KEY_START;
        end else if (inc) begin
            q <= q + KEY_WIDTH'(1);
        end
    end

    assign is_last = (q == KEY_END);

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Brute-force RC4 key-search sequencer driving the KSA/decrypt datapath one candidate at a time.
// Define RC4_KEY_SEARCH_TIMEOUT_EN to add the per-candidate watchdog and TIMEOUT state.
module rc4_key_search_ctrl #(
    parameter int                   KEY_WIDTH      = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_START      = 24'h000000,
    parameter logic [KEY_WIDTH-1:0] KEY_END        = 24'h3FFFFF,
    parameter int                   TIMEOUT_CYCLES = 65536
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        search_start,
    input  logic                        search_abort,
    rc4_key_search_ctrl_if.master       dp,
    output logic                        busy,
    output logic                        key_found,
    output logic                        key_exhausted,
    output logic [KEY_WIDTH-1:0]        keys_tried,
    output logic                        dp_timeout
);

    import rc4_pkg::*;

    if (KEY_END < KEY_START) begin : g_range_check
        $error("rc4_key_search_ctrl: KEY_END is below KEY_START");
    end

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("rc4_key_search_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    key_search_state_t    state;
    key_search_state_t    state_nxt;
    logic [KEY_WIDTH-1:0] key_q;
    logic                 key_is_last;
    logic                 key_load;
    logic                 key_inc;
    logic                 wait_done;
    logic                 wd_expire;

    assign busy       = (state == ST_LAUNCH) || (state == ST_WAIT);
    assign key_load   = !busy && search_start;
    // Abort outranks a coincident dp_done, so that completion is simply dropped.
    assign wait_done  = (state == ST_WAIT) && dp.dp_done && !search_abort;
    assign key_inc    = wait_done && !dp.dp_key_found && !key_is_last;

    assign dp.dp_start   = (state == ST_LAUNCH);
    assign dp.secret_key = key_q;

    rc4_key_counter #(
        .KEY_WIDTH (KEY_WIDTH),
        .KEY_START (KEY_START),
        .KEY_END   (KEY_END)
    ) u_key_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (key_load),
        .inc     (key_inc),
        .q       (key_q),
        .is_last (key_is_last)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LAUNCH: begin
                state_nxt = search_abort ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (search_abort) begin
                    state_nxt = ST_IDLE;
                end else if (dp.dp_done) begin
                    if (dp.dp_key_found) begin
                        state_nxt = ST_FOUND;
                    end else if (key_is_last) begin
                        state_nxt = ST_EXHAUSTED;
                    end else begin
                        state_nxt = ST_LAUNCH;
                    end
                end
`ifdef RC4_KEY_SEARCH_TIMEOUT_EN
                else if (wd_expire) begin
                    state_nxt = ST_TIMEOUT;
                end
`endif
            end
            default: begin
                if (search_start) begin
                    state_nxt = ST_LAUNCH;
                end
            end
        endcase
    end

    // Starting a new search wipes the previous verdict and count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            keys_tried    <= '0;
            key_found     <= 1'b0;
            key_exhausted <= 1'b0;
        end else begin
            state <= state_nxt;
            if (key_load) begin
                keys_tried    <= '0;
                key_found     <= 1'b0;
                key_exhausted <= 1'b0;
            end else if (wait_done) begin
                keys_tried <= keys_tried + KEY_WIDTH'(1);
                if (dp.dp_key_found) begin
                    key_found <= 1'b1;
                end else if (key_is_last) begin
                    key_exhausted <= 1'b1;
                end
            end
        end
    end

`ifdef RC4_KEY_SEARCH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdog;
    logic            timeout_q;

    assign wd_expire  = (state == ST_WAIT) && !dp.dp_done && !search_abort
                        && (wdog == WD_W'(TIMEOUT_CYCLES - 1));
    assign dp_timeout = timeout_q;

    // The watchdog sits at zero outside WAIT, so it restarts for every candidate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state != ST_WAIT) begin
                wdog <= '0;
            end else if (!wd_expire) begin
                wdog <= wdog + WD_W'(1);
            end
            if (key_load) begin
                timeout_q <= 1'b0;
            end else if (wd_expire) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign wd_expire  = 1'b0;
    assign dp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Self-checking bench for rc4_key_search_ctrl over the key range 0..3 with a behavioural datapath.
// The timeout scenario runs only when RC4_KEY_SEARCH_TIMEOUT_EN is defined.
module tb_rc4_key_search_ctrl;

    localparam int          KW = 24;
    localparam logic [23:0] KS = 24'h000000;
    localparam logic [23:0] KE = 24'h000003;
    localparam int          TO = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          search_start = 1'b0;
    logic          search_abort = 1'b0;
    logic          busy;
    logic          key_found;
    logic          key_exhausted;
    logic [KW-1:0] keys_tried;
    logic          dp_timeout;

    int checks = 0;
    int errors = 0;

    rc4_key_search_ctrl_if #(.KEY_WIDTH(KW)) dif();

    rc4_key_search_ctrl #(
        .KEY_WIDTH      (KW),
        .KEY_START      (KS),
        .KEY_END        (KE),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .search_start  (search_start),
        .search_abort  (search_abort),
        .dp            (dif),
        .busy          (busy),
        .key_found     (key_found),
        .key_exhausted (key_exhausted),
        .keys_tried    (keys_tried),
        .dp_timeout    (dp_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Datapath stand-in: answers each dp_start after dp_latency cycles (0 = never answers).
    int          dp_latency = 1;
    bit          match_en   = 1'b0;
    logic [23:0] match_key  = '0;
    int          pend       = 0;
    logic [23:0] cur_key    = '0;
    logic [23:0] launched_q[$];

    always @(negedge clk) begin
        dif.dp_done      = 1'b0;
        dif.dp_key_found = 1'b0;
        if (!reset_n) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    dif.dp_done      = 1'b1;
                    dif.dp_key_found = match_en && (cur_key == match_key);
                end
            end
            if (dif.dp_start) begin
                launched_q.push_back(dif.secret_key);
                cur_key = dif.secret_key;
                pend    = dp_latency;
            end
        end
    end

    // Reference model: search active flag, pending launch, current candidate and tallies.
    bit          m_busy   = 1'b0;
    bit          m_launch = 1'b0;
    logic [23:0] m_key    = KS;
    logic [23:0] m_tried  = '0;
    bit          m_found  = 1'b0;
    bit          m_exh    = 1'b0;
    bit          m_to     = 1'b0;
    int          m_wait   = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_launch = 0; m_key = KS; m_tried = '0;
            m_found = 0; m_exh = 0; m_to = 0; m_wait = 0;
        end else if (m_busy) begin
            if (search_abort) begin
                m_busy = 0; m_launch = 0;
            end else if (m_launch) begin
                m_launch = 0; m_wait = 0;
            end else if (dif.dp_done) begin
                m_tried = m_tried + 24'd1;
                if (dif.dp_key_found) begin
                    m_found = 1; m_busy = 0;
                end else if (m_key == KE) begin
                    m_exh = 1; m_busy = 0;
                end else begin
                    m_key = m_key + 24'd1; m_launch = 1;
                end
            end
`ifdef RC4_KEY_SEARCH_TIMEOUT_EN
            else begin
                m_wait++;
                if (m_wait == TO) begin
                    m_to = 1; m_busy = 0;
                end
            end
`endif
        end else if (search_start) begin
            m_key = KS; m_tried = '0; m_found = 0; m_exh = 0; m_to = 0;
            m_busy = 1; m_launch = 1;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("cyc_busy",          32'(busy),           32'(m_busy));
            check("cyc_dp_start",      32'(dif.dp_start),   32'(m_busy && m_launch));
            check("cyc_secret_key",    32'(dif.secret_key), 32'(m_key));
            check("cyc_keys_tried",    32'(keys_tried),     32'(m_tried));
            check("cyc_key_found",     32'(key_found),      32'(m_found));
            check("cyc_key_exhausted", 32'(key_exhausted),  32'(m_exh));
            check("cyc_dp_timeout",    32'(dp_timeout),     32'(m_to));
        end
    end

    task automatic apply_stimulus(input int latency, input bit match, input logic [23:0] mkey);
        dp_latency = latency;
        match_en   = match;
        match_key  = mkey;
        launched_q.delete();
        @(negedge clk);
        search_start = 1'b1;
        @(negedge clk);
        search_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done_ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #1;
            if (!busy) begin
                done_ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!done_ok) begin
            errors++;
            $display("[TB] FAIL %s: busy still 1 after 500 cycles, expected 0", name);
        end
    endtask

    task automatic check_output(input string name, input int n_launch, input logic [23:0] key,
                                input logic [23:0] tried, input bit found, input bit exh);
        check({name, "_launches"},     32'(launched_q.size()), 32'(n_launch));
        check({name, "_secret_key"},   32'(dif.secret_key),    32'(key));
        check({name, "_keys_tried"},   32'(keys_tried),        32'(tried));
        check({name, "_key_found"},    32'(key_found),         32'(found));
        check({name, "_key_exhausted"},32'(key_exhausted),     32'(exh));
        check({name, "_busy"},         32'(busy),              32'd0);
    endtask

    initial begin
        bit hit;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",       32'(busy),           32'd0);
        check("rst_dp_start",   32'(dif.dp_start),   32'd0);
        check("rst_secret_key", 32'(dif.secret_key), 32'(KS));
        check("rst_keys_tried", 32'(keys_tried),     32'd0);
        check("rst_flags",      32'({key_found, key_exhausted, dp_timeout}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] match on key 2, with a start request while busy");
        apply_stimulus(3, 1'b1, 24'd2);
        repeat (2) @(negedge clk);
        search_start = 1'b1;
        @(negedge clk);
        search_start = 1'b0;
        wait_idle("match_wait");
        check_output("match", 3, 24'd2, 24'd3, 1'b1, 1'b0);
        if (launched_q.size() == 3) begin
            check("match_key0", 32'(launched_q[0]), 32'd0);
            check("match_key1", 32'(launched_q[1]), 32'd1);
            check("match_key2", 32'(launched_q[2]), 32'd2);
        end

        $display("[TB] restart after FOUND, then exhaust the range");
        dp_latency = 1;
        match_en   = 1'b0;
        launched_q.delete();
        @(negedge clk);
        search_start = 1'b1;
        @(negedge clk);
        search_start = 1'b0;
        #1;
        check("restart_key_found",  32'(key_found),      32'd0);
        check("restart_secret_key", 32'(dif.secret_key), 32'(KS));
        check("restart_dp_start",   32'(dif.dp_start),   32'd1);
        wait_idle("exhaust_wait");
        repeat (5) @(negedge clk);
        #1;
        check_output("exhaust", 4, 24'd3, 24'd4, 1'b0, 1'b1);

        $display("[TB] abort coinciding with dp_done of key 1");
        apply_stimulus(2, 1'b0, 24'd0);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (dif.dp_done && dif.secret_key == 24'd1) begin
                hit = 1'b1;
                break;
            end
        end
        check("abort_reached_key1_done", 32'(hit), 32'd1);
        search_abort = 1'b1;
        @(negedge clk);
        search_abort = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check_output("abort", 2, 24'd1, 24'd1, 1'b0, 1'b0);

        $display("[TB] asynchronous reset in the middle of WAIT");
        apply_stimulus(5, 1'b0, 24'd0);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (launched_q.size() == 2 && !dif.dp_start && busy) begin
                hit = 1'b1;
                break;
            end
        end
        check("areset_reached_wait", 32'(hit), 32'd1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_busy",       32'(busy),           32'd0);
        check("areset_dp_start",   32'(dif.dp_start),   32'd0);
        check("areset_secret_key", 32'(dif.secret_key), 32'(KS));
        check("areset_keys_tried", 32'(keys_tried),     32'd0);
        check("areset_flags",      32'({key_found, key_exhausted, dp_timeout}), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        apply_stimulus(1, 1'b1, 24'd0);
        wait_idle("after_reset_wait");
        check_output("after_reset", 1, 24'd0, 24'd1, 1'b1, 1'b0);
        if (launched_q.size() == 1) begin
            check("after_reset_key0", 32'(launched_q[0]), 32'(KS));
        end

`ifdef RC4_KEY_SEARCH_TIMEOUT_EN
        $display("[TB] watchdog timeout with a silent datapath");
        apply_stimulus(0, 1'b0, 24'd0);
        wait_idle("timeout_wait");
        check("timeout_flag",       32'(dp_timeout),     32'd1);
        check("timeout_secret_key", 32'(dif.secret_key), 32'(KS));
        check("timeout_busy",       32'(busy),           32'd0);
        check("timeout_launches",   32'(launched_q.size()), 32'd1);
        apply_stimulus(1, 1'b0, 24'd0);
        #1;
        check("timeout_cleared", 32'(dp_timeout), 32'd0);
        wait_idle("timeout_restart_wait");
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
